// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the multi-requester RAM arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ID_W   = 3;
    localparam int unsigned CNT_W  = 2;

    localparam logic [ADDR_W-1:0] ADDR_LIMIT_DEFAULT = 16'hC000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACK   = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    // One requester's transaction as latched by the arbiter.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mem_req_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational request picker: round-robin after ptr, or fixed lowest-index
// priority when MEM_ARB_FIXED_PRIO_EN is defined.
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3
)(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               valid_c,
    output logic [ID_W-1:0]    winner_c
);

    // Lowest set index is the fallback; in rotation mode the lowest index
    // above ptr overrides it, which gives wrap-around from ptr+1.
    always_comb begin
        valid_c  = |req;
        winner_c = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner_c = ID_W'(i);
            end
        end
`ifndef MEM_ARB_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (i > int'(ptr))) begin
                winner_c = ID_W'(i);
            end
        end
`endif
    end

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates NUM_REQ requesters onto one synchronous-read RAM, one access at a time.
// Define MEM_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned       NUM_REQ     = 3,
    parameter int unsigned       RAM_LATENCY = 1,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT  = ADDR_LIMIT_DEFAULT
)(
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [NUM_REQ-1:0]          REQ_ENABLE,
    input  logic [NUM_REQ-1:0]          REQ_WRITE,
    input  logic [ADDR_W*NUM_REQ-1:0]   REQ_ADDR,
    input  logic [DATA_W*NUM_REQ-1:0]   REQ_DATA_W,
    output logic [NUM_REQ-1:0]          REQ_ACK,
    output logic [NUM_REQ-1:0]          REQ_ERR,
    output logic [DATA_W-1:0]           REQ_DATA_R,
    output logic [ID_W-1:0]             GRANT_ID,
    output logic                        BUSY,
    output logic                        RAM_EN,
    output logic                        RAM_WE,
    output logic [ADDR_W-1:0]           RAM_ADDR,
    output logic [DATA_W-1:0]           RAM_DIN,
    input  logic [DATA_W-1:0]           RAM_DOUT
);

    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(RAM_LATENCY - 1);
    localparam logic [ID_W-1:0]    PTR_INIT = ID_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    mem_req_t            lat_q, lat_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [NUM_REQ-1:0]  err_q, err_d;
    logic                busy_q, busy_d;
    logic                ram_en_q, ram_en_d;
    logic                ram_we_q, ram_we_d;

    logic                pick_valid_c;
    logic [ID_W-1:0]     pick_id_c;
    mem_req_t            sel_req_c;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req      (REQ_ENABLE),
        .ptr      (ptr_q),
        .valid_c  (pick_valid_c),
        .winner_c (pick_id_c)
    );

    // Route the picked requester's transaction fields.
    always_comb begin
        sel_req_c = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_id_c == ID_W'(i)) begin
                sel_req_c.we   = REQ_WRITE[i];
                sel_req_c.addr = REQ_ADDR[i*ADDR_W +: ADDR_W];
                sel_req_c.data = REQ_DATA_W[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and next-output logic; every output register is driven from here.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        lat_d    = lat_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        ack_d    = '0;
        err_d    = '0;
        ram_en_d = 1'b0;
        ram_we_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid_c) begin
                    grant_d = pick_id_c;
                    lat_d   = sel_req_c;
                    if (sel_req_c.addr >= ADDR_LIMIT) begin
                        state_d = ST_ERR;
                        err_d   = ONE_HOT0 << pick_id_c;
                    end else begin
                        state_d  = ST_ISSUE;
                        ram_en_d = 1'b1;
                        ram_we_d = sel_req_c.we;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d = lat_q.we ? '0 : RAM_DOUT;
                    ack_d   = ONE_HOT0 << grant_q;
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACK, ST_ERR: begin
                ptr_d   = grant_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            ptr_q    <= PTR_INIT;
            grant_q  <= '0;
            lat_q    <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            ack_q    <= '0;
            err_q    <= '0;
            busy_q   <= 1'b0;
            ram_en_q <= 1'b0;
            ram_we_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            lat_q    <= lat_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            ram_en_q <= ram_en_d;
            ram_we_q <= ram_we_d;
        end
    end

    assign REQ_ACK    = ack_q;
    assign REQ_ERR    = err_q;
    assign REQ_DATA_R = rdata_q;
    assign GRANT_ID   = grant_q;
    assign BUSY       = busy_q;
    assign RAM_EN     = ram_en_q;
    assign RAM_WE     = ram_we_q;
    assign RAM_ADDR   = lat_q.addr;
    assign RAM_DIN    = lat_q.data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at RAM latency 1, one at latency 3.
module tb_mem_arbiter;

    logic        CLK;
    logic        RESET;
    logic        RESET3;
    logic        mem_init;
    logic [2:0]  en1, en3, wr;
    logic [15:0] a [3];
    logic [15:0] d [3];
    logic [47:0] req_addr, req_data;

    logic [2:0]  ack1, err1, gid1, ack3, err3, gid3;
    logic [15:0] rdata1, ram_addr1, ram_din1, dout1;
    logic [15:0] rdata3, ram_addr3, ram_din3, dout3;
    logic        busy1, ram_en1, ram_we1, busy3, ram_en3, ram_we3;

    logic [15:0] mem1 [1024];
    logic [15:0] mem3 [1024];
    logic [15:0] p3 [3];
    logic [15:0] exp_rd [3];

    int checks;
    int errors;
    int exp_id;

    assign req_addr = {a[2], a[1], a[0]};
    assign req_data = {d[2], d[1], d[0]};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    mem_arbiter #(.NUM_REQ(3), .RAM_LATENCY(1), .ADDR_LIMIT(16'hC000)) dut1 (
        .CLK(CLK), .RESET(RESET), .REQ_ENABLE(en1), .REQ_WRITE(wr),
        .REQ_ADDR(req_addr), .REQ_DATA_W(req_data), .REQ_ACK(ack1), .REQ_ERR(err1),
        .REQ_DATA_R(rdata1), .GRANT_ID(gid1), .BUSY(busy1), .RAM_EN(ram_en1),
        .RAM_WE(ram_we1), .RAM_ADDR(ram_addr1), .RAM_DIN(ram_din1), .RAM_DOUT(dout1)
    );

    mem_arbiter #(.NUM_REQ(3), .RAM_LATENCY(3), .ADDR_LIMIT(16'hC000)) dut3 (
        .CLK(CLK), .RESET(RESET3), .REQ_ENABLE(en3), .REQ_WRITE(wr),
        .REQ_ADDR(req_addr), .REQ_DATA_W(req_data), .REQ_ACK(ack3), .REQ_ERR(err3),
        .REQ_DATA_R(rdata3), .GRANT_ID(gid3), .BUSY(busy3), .RAM_EN(ram_en3),
        .RAM_WE(ram_we3), .RAM_ADDR(ram_addr3), .RAM_DIN(ram_din3), .RAM_DOUT(dout3)
    );

    // RAM models: data appears RAM_LATENCY cycles after the strobe cycle, poison otherwise.
    always @(posedge CLK) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem1[i] <= 16'h0000;
            mem1[10'h010] <= 16'hBEEF;
            mem1[10'h011] <= 16'h5A5A;
            mem1[10'h3FF] <= 16'hC0DE;
        end else if (ram_en1 && ram_we1) begin
            mem1[ram_addr1[9:0]] <= ram_din1;
        end
        dout1 <= ram_en1 ? mem1[ram_addr1[9:0]] : 16'hDEAD;
    end

    always @(posedge CLK) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem3[i] <= 16'h0000;
            mem3[10'h010] <= 16'h7777;
        end else if (ram_en3 && ram_we3) begin
            mem3[ram_addr3[9:0]] <= ram_din3;
        end
        p3[0] <= ram_en3 ? mem3[ram_addr3[9:0]] : 16'hDEAD;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign dout3 = p3[2];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_rd[0] = 16'hBEEF;
        exp_rd[1] = 16'h1234;
        exp_rd[2] = 16'h5A5A;
        RESET = 1'b1;
        RESET3 = 1'b1;
        mem_init = 1'b1;
        en1 = '0;
        en3 = '0;
        wr = '0;
        for (int i = 0; i < 3; i++) begin
            a[i] = '0;
            d[i] = '0;
        end
        tick(2);

        // Reset values
        check("rst_ack", ack1, 0);
        check("rst_err", err1, 0);
        check("rst_rdata", rdata1, 0);
        check("rst_gid", gid1, 0);
        check("rst_busy", busy1, 0);
        check("rst_ram_en", ram_en1, 0);
        check("rst_ram_addr", ram_addr1, 0);
        check("rst_ram_din", ram_din1, 0);
        RESET = 1'b0;
        mem_init = 1'b0;
        tick(1);

        // Single read by requester 1
        en1 = 3'b010; a[1] = 16'h0010;
        tick(1);
        check("rd_ram_en", ram_en1, 1);
        check("rd_ram_we", ram_we1, 0);
        check("rd_ram_addr", ram_addr1, 16'h0010);
        check("rd_gid", gid1, 1);
        check("rd_busy", busy1, 1);
        tick(1);
        check("rd_ram_en_off", ram_en1, 0);
        check("rd_no_early_ack", ack1, 0);
        tick(1);
        check("rd_ack", ack1, 3'b010);
        check("rd_data", rdata1, 16'hBEEF);
        en1 = '0;
        tick(1);
        check("rd_ack_pulse", ack1, 0);
        check("rd_idle", busy1, 0);
        check("rd_data_hold", rdata1, 16'hBEEF);

        // Write then read back by requester 0
        en1 = 3'b001; wr = 3'b001; a[0] = 16'h0200; d[0] = 16'h1234;
        tick(1);
        check("wr_ram_en", ram_en1, 1);
        check("wr_ram_we", ram_we1, 1);
        check("wr_ram_addr", ram_addr1, 16'h0200);
        check("wr_ram_din", ram_din1, 16'h1234);
        tick(1);
        check("wr_we_off", ram_we1, 0);
        tick(1);
        check("wr_ack", ack1, 3'b001);
        check("wr_data_zero", rdata1, 0);
        en1 = '0; wr = '0;
        tick(1);
        en1 = 3'b001;
        tick(3);
        check("rb_ack", ack1, 3'b001);
        check("rb_data", rdata1, 16'h1234);
        en1 = '0;
        tick(1);

        // Last legal address is accepted
        en1 = 3'b100; a[2] = 16'hBFFF;
        tick(1);
        check("lim_ram_en", ram_en1, 1);
        tick(2);
        check("lim_ack", ack1, 3'b100);
        check("lim_data", rdata1, 16'hC0DE);
        en1 = '0;
        tick(1);

        // First illegal address is rejected by requester 1
        en1 = 3'b010; a[1] = 16'hC000;
        tick(1);
        check("err_pulse", err1, 3'b010);
        check("err_ram_en", ram_en1, 0);
        check("err_ack", ack1, 0);
        check("err_gid", gid1, 1);
        en1 = '0;
        tick(1);
        check("err_pulse_end", err1, 0);
        check("err_ram_en2", ram_en1, 0);
        check("err_idle", busy1, 0);

        // Contention: pointer now at 1, so rotation starts at 2
        a[0] = 16'h0010; a[1] = 16'h0200; a[2] = 16'h0011;
        en1 = 3'b111;
        for (int k = 0; k < 6; k++) begin
            tick(k == 0 ? 3 : 4);
`ifdef MEM_ARB_FIXED_PRIO_EN
            exp_id = 0;
`else
            exp_id = (k + 2) % 3;
`endif
            check("cont_ack", ack1, 32'(3'b001 << exp_id));
            check("cont_gid", gid1, 32'(exp_id));
            check("cont_data", rdata1, exp_rd[exp_id]);
        end
        en1 = '0;
        tick(1);

        // Winner drops its request right after being granted
        en1 = 3'b010;
        tick(1);
        en1 = '0;
        check("drop_ram_en", ram_en1, 1);
        tick(2);
        check("drop_ack", ack1, 3'b010);
        check("drop_data", rdata1, 16'h1234);
        tick(1);
        check("drop_ack_end", ack1, 0);

        // Latency-3 instance: one full read
        RESET3 = 1'b0;
        a[0] = 16'h0010; a[1] = 16'h0010; a[2] = 16'h0010;
        tick(1);
        en3 = 3'b001;
        tick(4);
        check("l3_no_early_ack", ack3, 0);
        tick(1);
        check("l3_ack", ack3, 3'b001);
        check("l3_data", rdata3, 16'h7777);
        en3 = '0;
        tick(1);

        // Reset while waiting on the RAM
        en3 = 3'b100;
        tick(2);
        check("l3_wait_busy", busy3, 1);
        check("l3_wait_gid", gid3, 2);
        RESET3 = 1'b1;
        en3 = '0;
        tick(1);
        check("l3_rst_ram_en", ram_en3, 0);
        check("l3_rst_busy", busy3, 0);
        check("l3_rst_ack", ack3, 0);
        check("l3_rst_gid", gid3, 0);
        check("l3_rst_rdata", rdata3, 0);
        check("l3_rst_ram_addr", ram_addr3, 0);
        RESET3 = 1'b0;
        tick(1);
        check("l3_no_ack_a", ack3, 0);
        tick(1);
        check("l3_no_ack_b", ack3, 0);
        en3 = 3'b111;
        tick(5);
        check("l3_post_rst_ack", ack3, 3'b001);
        check("l3_post_rst_gid", gid3, 0);
        en3 = '0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
